// File: rtl/iq_prod_serdes_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_pkg (package)
// Description : Shared constants, types and the header-beat builder for the
//               IQ-product serialiser (iq_prod_serdes_tx).
//               Contents:
//                 IQ_PROD_W / SAMPLE_W / NUM_CH : IQ-product word geometry
//                 HDR_MAGIC                     : packet header marker
//                 iq_prod_word_t                : one 512-bit product word
//                 serdes_state_t                : IDLE / HDR / STREAM
//                 hdr_word()                    : 64-bit packet header beat
// Revision    : 1.0 - initial release
// ============================================================================
package iq_pkg;

  localparam int          IQ_PROD_W = 512;
  localparam int          SAMPLE_W  = 16;
  localparam int          NUM_CH    = 4;
  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

  typedef logic [IQ_PROD_W-1:0] iq_prod_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2
  } serdes_state_t;

  // Header beat: magic, running packet count, words per packet, reserved.
  function automatic logic [63:0] hdr_word(input logic [15:0] cnt,
                                           input logic [15:0] words);
    return {HDR_MAGIC, cnt, words, 16'h0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_prod_serdes_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : iq_prod_serdes_tx_if
// Description : AXI-Stream bundle used on both sides of the serialiser.
//               Parameter W : tdata width.
//               Signals     : tdata, tvalid, tready, tlast.
//               master      : drives tdata/tvalid/tlast, samples tready.
//               slave       : samples tdata/tvalid, drives tready (the input
//                             side carries no packet framing, so tlast is
//                             not part of the slave view).
// Revision    : 1.0 - initial release
// ============================================================================
interface iq_prod_serdes_tx_if #(
  parameter int W = 64
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/iq_prod_serdes_tx_beat_mux.sv
`default_nettype none
// ============================================================================
// Module      : iq_beat_mux
// Description : Pure lane selector: picks OUT_W-bit lane beat_idx out of the
//               held IN_W-bit word. Lane 0 is bits [OUT_W-1:0].
//               Ports:
//                 hold     in  IN_W   held input word
//                 beat_idx in  IDX_W  lane index (0..BEATS-1)
//                 beat     out OUT_W  selected lane
// Revision    : 1.0 - initial release
// ============================================================================
module iq_beat_mux #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 64,
  parameter int BEATS = IN_W / OUT_W,
  parameter int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  wire logic [IN_W-1:0]  hold,
  input  wire logic [IDX_W-1:0] beat_idx,
  output logic      [OUT_W-1:0] beat
);

  logic [OUT_W-1:0] w_lanes [BEATS];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign w_lanes[gi] = hold[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign beat = w_lanes[beat_idx];

endmodule
`default_nettype wire

// File: rtl/iq_prod_serdes_tx.sv
`default_nettype none
// ============================================================================
// Module      : iq_prod_serdes_tx
// Description : Buffers one 512-bit IQ-product word and serialises it into
//               OUT_W-bit AXI-Stream beats, grouping PKT_WORDS words into one
//               DMA packet framed by tlast. A new word may load in the cycle
//               the last beat of the current word leaves, so a sustained
//               stream has no bubbles.
//               Optional build macro IQ_SERDES_HDR_EN: prepend one header beat
//               {A5C3, pkt_cnt, PKT_WORDS, 0000} to every packet.
//               Ports:
//                 aclk     in   clock, rising edge
//                 aresetn  in   asynchronous active-low reset
//                 s_axis   slave  IN_W-bit input word stream
//                 m_axis   master OUT_W-bit output beat stream with tlast
//                 pkt_cnt  out  16-bit completed-packet counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module iq_prod_serdes_tx
  import iq_pkg::*;
#(
  parameter int IN_W      = 512,
  parameter int OUT_W     = 64,
  parameter int PKT_WORDS = 4
) (
  input  wire logic           aclk,
  input  wire logic           aresetn,
  iq_prod_serdes_tx_if.slave  s_axis,
  iq_prod_serdes_tx_if.master m_axis,
  output logic [15:0]         pkt_cnt
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int B_W   = (BEATS > 1)     ? $clog2(BEATS)     : 1;
  localparam int W_W   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [B_W-1:0] C_LAST_BEAT = B_W'(BEATS - 1);
  localparam logic [W_W-1:0] C_LAST_WORD = W_W'(PKT_WORDS - 1);

  serdes_state_t    r_state;
  logic [IN_W-1:0]  r_hold;
  logic [B_W-1:0]   r_beat_idx;
  logic [W_W-1:0]   r_word_idx;
  logic [15:0]      r_pkt_cnt;
  // Goes high on the first clock after reset release; keeps s_axis.tready
  // low until then so the release edge itself never accepts a word.
  logic             r_live;

  logic             w_beat_last;
  logic             w_word_last;
  logic [W_W-1:0]   w_word_nxt;
  logic             w_s_hs;
  logic             w_m_hs;
  logic [OUT_W-1:0] w_beat;
  serdes_state_t    w_st_idle;
  serdes_state_t    w_st_next;

  assign w_beat_last = (r_beat_idx == C_LAST_BEAT);
  assign w_word_last = (r_word_idx == C_LAST_WORD);
  assign w_word_nxt  = w_word_last ? '0 : r_word_idx + 1'b1;

  // Ready while empty, or while the final beat of the held word is leaving.
  assign s_axis.tready = r_live &&
                         ((r_state == IDLE) ||
                          ((r_state == STREAM) && w_beat_last && m_axis.tready));

  assign w_s_hs = s_axis.tvalid && s_axis.tready;
  assign w_m_hs = m_axis.tvalid && m_axis.tready;

  iq_beat_mux #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BEATS (BEATS),
    .IDX_W (B_W)
  ) u_beat_mux (
    .hold     (r_hold),
    .beat_idx (r_beat_idx),
    .beat     (w_beat)
  );

  assign m_axis.tvalid = (r_state != IDLE);
  assign m_axis.tlast  = (r_state == STREAM) && w_beat_last && w_word_last;
  assign pkt_cnt       = r_pkt_cnt;

`ifdef IQ_SERDES_HDR_EN
  // A word that opens a packet (word index 0) is preceded by a header beat.
  assign w_st_idle     = (r_word_idx == '0) ? HDR : STREAM;
  assign w_st_next     = (w_word_nxt == '0) ? HDR : STREAM;
  assign m_axis.tdata  = (r_state == HDR) ?
                         OUT_W'(hdr_word(r_pkt_cnt, 16'(PKT_WORDS))) : w_beat;
`else
  assign w_st_idle     = STREAM;
  assign w_st_next     = STREAM;
  assign m_axis.tdata  = w_beat;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live     <= 1'b0;
      r_state    <= IDLE;
      r_hold     <= '0;
      r_beat_idx <= '0;
      r_word_idx <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_s_hs) begin
            r_hold     <= s_axis.tdata;
            r_beat_idx <= '0;
            r_state    <= w_st_idle;
          end
        end
`ifdef IQ_SERDES_HDR_EN
        HDR: begin
          if (w_m_hs) begin
            r_state <= STREAM;
          end
        end
`endif
        STREAM: begin
          if (w_m_hs) begin
            if (w_beat_last) begin
              r_beat_idx <= '0;
              r_word_idx <= w_word_nxt;
              if (w_word_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
              end
              // Back-to-back load keeps the buffer full with no idle cycle.
              if (w_s_hs) begin
                r_hold  <= s_axis.tdata;
                r_state <= w_st_next;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_beat_idx <= r_beat_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_prod_serdes_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_prod_serdes_tx
// Description : Self-checking bench for iq_prod_serdes_tx. Randomised input
//               words and output backpressure; each accepted word is expanded
//               by a packet-level reference model into its expected beats
//               (plus a header beat when IQ_SERDES_HDR_EN is defined) and
//               queued; a monitor pops and compares every accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_prod_serdes_tx;

  localparam int IN_W      = 512;
  localparam int OUT_W     = 64;
  localparam int PKT_WORDS = 4;
  localparam int BEATS     = IN_W / OUT_W;

  typedef struct {
    logic [63:0] d;
    bit          last;
    bit          lastw;
  } beat_t;

  logic        clk;
  logic        aresetn;
  logic [15:0] pkt_cnt;

  iq_prod_serdes_tx_if #(.W(IN_W))  s_if ();
  iq_prod_serdes_tx_if #(.W(OUT_W)) m_if ();

  iq_prod_serdes_tx #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .PKT_WORDS (PKT_WORDS)
  ) dut (
    .aclk    (clk),
    .aresetn (aresetn),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nerr = 0;
  beat_t       q[$];
  int          wc;
  int          exp_cnt;
  bit          pend;
  bit          stall;
  logic [63:0] stall_d;
  logic        stall_l;
  bit          live;
  int          pkt_beats;
  int          cyc_n;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: split an accepted word into its packet beats.
  task automatic model_push(input logic [IN_W-1:0] w);
    int    widx;
    beat_t b;
    widx = wc % PKT_WORDS;
`ifdef IQ_SERDES_HDR_EN
    if (widx == 0) begin
      b.d     = {16'hA5C3, 16'(wc / PKT_WORDS), 16'(PKT_WORDS), 16'h0000};
      b.last  = 1'b0;
      b.lastw = 1'b0;
      q.push_back(b);
    end
`endif
    for (int k = 0; k < BEATS; k++) begin
      b.d     = w[k*OUT_W +: OUT_W];
      b.last  = (k == BEATS-1) && (widx == PKT_WORDS-1);
      b.lastw = (k == BEATS-1);
      q.push_back(b);
    end
    wc++;
  endtask

  // Monitor / scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (aresetn) begin
      beat_t e;
      logic  exp_rdy;
      if (pend) begin
        check(pkt_cnt == 16'(exp_cnt), "pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
        pend = 1'b0;
      end
      if (stall) begin
        check(m_if.tvalid && (m_if.tdata == stall_d) && (m_if.tlast == stall_l),
              "stall_stable", {m_if.tdata[62:0], m_if.tlast}, {stall_d[62:0], stall_l});
      end
      exp_rdy = live && ((q.size() == 0) || (q[0].lastw && m_if.tready));
      check(s_if.tready == exp_rdy, "s_tready", 64'(s_if.tready), 64'(exp_rdy));
      check(m_if.tvalid == (q.size() != 0), "m_tvalid", 64'(m_if.tvalid), 64'(q.size() != 0));
      stall   = m_if.tvalid && !m_if.tready;
      stall_d = m_if.tdata;
      stall_l = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_beat", m_if.tdata, 64'h0);
        end else begin
          e = q.pop_front();
          check(m_if.tdata == e.d, "beat_tdata", m_if.tdata, e.d);
          check(m_if.tlast == e.last, "beat_tlast", 64'(m_if.tlast), 64'(e.last));
          pkt_beats++;
          if (e.last) begin
            exp_cnt++;
            pend      = 1'b1;
            pkt_beats = 0;
          end
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        model_push(s_if.tdata);
      end
    end
  end

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // vmode: 0 off, 1 on, 2 random.  rmode: 0 on, 1 toggle, 2 random.
  // pat: drive the lane-k = k word instead of random data.
  task automatic cyc(input int vmode, input int rmode, input bit pat);
    logic [IN_W-1:0] w;
    @(posedge clk);
    #1;
    cyc_n++;
    if (pat) begin
      for (int k = 0; k < BEATS; k++) w[k*OUT_W +: OUT_W] = 64'(k);
    end else begin
      w = rand_word();
    end
    s_if.tdata  = w;
    s_if.tvalid = (vmode == 1) || ((vmode == 2) && ($urandom_range(1, 0) == 1));
    m_if.tready = (rmode == 0) || ((rmode == 1) && cyc_n[0]) ||
                  ((rmode == 2) && ($urandom_range(3, 0) != 0));
  endtask

  task automatic clear_model();
    q.delete();
    wc        = 0;
    exp_cnt   = 0;
    pend      = 1'b0;
    stall     = 1'b0;
    live      = 1'b0;
    pkt_beats = 0;
  endtask

  initial begin
    int bubbles;
    int guard;
    clear_model();
    cyc_n       = 0;
    aresetn     = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(m_if.tvalid == 1'b0, "rst_tvalid", 64'(m_if.tvalid), 64'h0);
    check(m_if.tlast == 1'b0, "rst_tlast", 64'(m_if.tlast), 64'h0);
    check(m_if.tdata == 64'h0, "rst_tdata", m_if.tdata, 64'h0);
    check(s_if.tready == 1'b0, "rst_s_tready", 64'(s_if.tready), 64'h0);
    check(pkt_cnt == 16'h0, "rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
    #2 aresetn = 1'b1;
    @(posedge clk);
    #1 live = 1'b1;

    // Lane-pattern word: beats 0..7 in order
    cyc(1, 0, 1'b1);
    repeat (12) cyc(0, 0, 1'b0);

    // Back-to-back stream, no backpressure: no bubbles once started
    bubbles = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1, 0, 1'b0);
      @(negedge clk);
      if (i >= 2 && !m_if.tvalid) bubbles++;
    end
    check(bubbles == 0, "btb_bubbles", 64'(bubbles), 64'h0);

    // Alternating backpressure
    repeat (200) cyc(1, 1, 1'b0);
    // Random valid and ready
    repeat (600) cyc(2, 2, 1'b0);
    // Drain, then restart on a packet boundary after random activity
    repeat (120) cyc(0, 0, 1'b0);

    // Reset mid-packet: after beat 3 of word 2 of a fresh packet
    guard = 0;
    while (pkt_beats != 0 && guard < 200) begin cyc(0, 0, 1'b0); guard++; end
    while (pkt_beats != (2*BEATS + 3 - 1) && guard < 400) begin
      cyc(1, 0, 1'b0);
      guard++;
    end
    check(guard < 400, "midpkt_reach", 64'(guard), 64'd400);
    @(posedge clk);
    #3 aresetn = 1'b0;
    #1;
    check(m_if.tvalid == 1'b0, "async_rst_tvalid", 64'(m_if.tvalid), 64'h0);
    check(s_if.tready == 1'b0, "async_rst_s_tready", 64'(s_if.tready), 64'h0);
    check(pkt_cnt == 16'h0, "async_rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
    clear_model();
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk);
    #1 live = 1'b1;

    // Post-reset traffic: first tlast after exactly PKT_WORDS*BEATS beats
    repeat (300) cyc(2, 2, 1'b0);

    // Final drain
    guard = 0;
    while (q.size() != 0 && guard < 200) begin cyc(0, 0, 1'b0); guard++; end
    repeat (3) cyc(0, 0, 1'b0);
    check(q.size() == 0, "drain_empty", 64'(q.size()), 64'h0);
    check(pkt_cnt == 16'(exp_cnt), "final_pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
    check(exp_cnt > 0, "packets_seen", 64'(exp_cnt), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/iq_prod_serdes_tx.md
Name: iq_prod_serdes_tx

Overview:
- Downstream consumer of the 512-bit IQ-product word stream (axis_do0/axis_vo0) emitted by the IQ-product stage.
- Accepts one 512-bit word per handshake, buffers it, and serialises it into narrow OUT_W beats for the PS-side DMA (AXI-Stream master with tlast).
- Groups PKT_WORDS input words into one DMA packet and applies backpressure upstream.
- With the full/last-beat handshake below, a sustained stream runs without bubbles.

Parameters:
- IN_W, 512, input word width; must equal 32 x 16-bit products.
- OUT_W, 64, output beat width; IN_W % OUT_W == 0.
- PKT_WORDS, 4, input words per DMA packet (>=1).
- BEATS, IN_W/OUT_W (derived localparam, 8), output beats per input word.

Ports:
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  IN_W  IQ-product word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  block can take the word this cycle.
- m_axis_tdata  out  OUT_W  serialised beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  DMA accepts beat.
- m_axis_tlast  out  1  last beat of packet.
- pkt_cnt  out  16  completed-packet counter, wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - s_axis_tready=0 while aresetn low; 1 from the first cycle after release.
  - pkt_cnt=0, beat_idx=0, word_idx=0, state IDLE.
- Registers:
  - hold[IN_W-1:0] plus full flag.
  - beat_idx: 0..BEATS-1.
  - word_idx: 0..PKT_WORDS-1.
- States: IDLE (full=0) and STREAM (full=1). HDR is added only with the optional feature.
- s_axis_tready = !full || (beat_idx==BEATS-1 && m_axis_tready). Upstream may load a new word in the same cycle the last beat leaves, so there is no bubble.
- Input handshake (s_tvalid & s_tready):
  - hold <= s_axis_tdata, full <= 1, beat_idx <= 0.
  - Latency: first beat is valid 1 cycle after input acceptance.
- Output: m_axis_tdata = hold[beat_idx*OUT_W +: OUT_W]. Lane 0 (bits [OUT_W-1:0]) goes first. m_axis_tvalid = full.
- Output handshake (m_tvalid & m_tready):
  - beat_idx increments.
  - At BEATS-1, beat_idx wraps to 0 and word_idx increments, or wraps to 0 at PKT_WORDS-1.
  - full clears unless a new word is loaded in the same cycle.
- m_axis_tlast = full && beat_idx==BEATS-1 && word_idx==PKT_WORDS-1.
- pkt_cnt increments on each accepted tlast beat.
- Stability rule: while m_tvalid=1 and m_tready=0, tdata, tlast and tvalid hold stable (AXIS rule).
- s_axis_tvalid is never required to be stable by this block. Data is sampled only on handshake.
- Simultaneous last-beat accept and new-word accept: the new word loads and full stays 1.
- If upstream asserts valid without ready, nothing is lost. Upstream holds the word, per AXIS.
- Reset mid-packet: the partial packet is discarded; no tlast is emitted for it, and the next packet starts at word_idx=0.

Optional Feature:
- Macro: IQ_SERDES_HDR_EN.
- Defined:
  - Before the first beat of each packet (word_idx==0, beat_idx==0), emit one header beat in state HDR.
  - Header layout: {16'hA5C3, pkt_cnt[15:0], PKT_WORDS[15:0], 16'h0}, right-aligned in OUT_W. OUT_W must be >=64.
  - The header beat's tlast=0.
  - The header adds 1 cycle of latency, and s_axis_tready=0 during HDR.
  - Packet length becomes PKT_WORDS*BEATS+1 beats.
- Not defined: no HDR state; behaviour exactly as above.

Decomposition:
- Package iq_pkg:
  - IQ_PROD_W=512, SAMPLE_W=16, NUM_CH=4.
  - HDR_MAGIC=16'hA5C3.
  - typedef iq_prod_word_t (logic [511:0]).
  - enum serdes_state_t {IDLE, HDR, STREAM}.
- One natural sub-module: iq_beat_mux (purely indexed lane select, hold and beat_idx -> beat). All control stays in the top.

Test Plan:
- Single word, PKT_WORDS=1, m_tready=1, word = 64'h0..07 per lane (lane k = k) -> 8 beats with tdata 0..7 on consecutive cycles; tlast on beat 8 only; pkt_cnt=1.
- Back-to-back stream, PKT_WORDS=4, s_tvalid held 1, m_tready=1 -> 32 consecutive beats with no bubbles; s_tready is high exactly on cycles where beat_idx=7; tlast on beats 32 and 64.
- Backpressure: toggle m_tready 1010... -> each beat is repeated stable while tready=0; beat order is unchanged; s_tready stays 0 until beat 7 is accepted.
- Reset mid-packet: drop aresetn after 3 beats of word 2 -> tvalid=0 in the same cycle (async); after release, a new packet gives tlast after exactly PKT_WORDS*8 beats.
- pkt_cnt wrap: preload by running 65536 packets (PKT_WORDS=1) -> pkt_cnt returns to 0.
- IQ_SERDES_HDR_EN defined: first packet starts with beat 64'hA5C3_0000_0004_0000, followed by 32 data beats, and tlast on data beat 32; the second header carries pkt_cnt=1.
